pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline stage register, the successor to the fixed enable/bubble stage registers between pipeline stages.
- Carries one DATA_W payload per entry (e.g. {pc, ir}) under a valid/ready handshake, so stalls back-propagate without a global enable.
- Adds synchronous flush, an optional 2-entry skid buffer that breaks the ready timing path, and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 64, payload width in bits.
- SKID, 1, 1 = two entries with a registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of each performance counter.
- ZERO_INVALID, 1, 1 = out_data is forced to 0 whenever out_valid=0.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous discard of all held and incoming entries.
- in_valid, input, 1, upstream has a payload.
- in_ready, output, 1, stage can accept this cycle.
- in_data, input, DATA_W, upstream payload.
- out_valid, output, 1, downstream payload present.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, downstream payload.
- cnt_clr, input, 1, synchronous clear of both counters.
- stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.
- bubble_cnt, output, CNT_W, cycles with out_valid=0 and out_ready=1.

Behaviour:
- Reset (rst=0, asynchronous): both entries are invalid, stored data is 0, out_valid=0, out_data=0, stall_cnt=0 and bubble_cnt=0. in_ready=1 after reset when SKID=1; when SKID=0 it follows the formula below.
- Transfers: an input transfer occurs when in_valid&in_ready. An output transfer occurs when out_valid&out_ready.
- Latency: one cycle from an accepted input to out_valid when the stage is empty. The stage does not bypass input to output combinationally.
- SKID=1 state is main_v and skid_v. out_* is driven from main. in_ready=!skid_v, taken from a flop.
  - EMPTY (main_v=0): an input transfer loads main, giving HALF.
  - HALF (main_v=1, skid_v=0):
    - input and output transfer together: main takes in_data, stays HALF.
    - output transfer only: go to EMPTY.
    - input transfer only: load skid, giving FULL.
  - FULL (skid_v=1): in_ready=0. On an output transfer, skid moves to main and the state becomes HALF.
  - Order is preserved: main is always older than skid.
- SKID=0 is a single entry. in_ready = !out_valid | out_ready (combinational). An input transfer loads the entry. An output transfer with no input clears valid.
- flush=1 at the clock edge:
  - main_v and skid_v are cleared; stored data is set to 0.
  - Any input transfer in the same cycle is dropped.
  - Flush has priority over all transfers.
  - in_ready keeps its normal formula in the flush cycle.
  - The next cycle is EMPTY.
- Data is held stable while out_valid=1 and out_ready=0. Upstream must keep in_data stable while in_valid=1 and in_ready=0.
- out_data is 0 when out_valid=0 and ZERO_INVALID=1. Otherwise it shows the stale main data.
- Counters:
  - Each counter is incremented at the clock edge on its condition, evaluated on that cycle's out_valid/out_ready.
  - Each saturates at 2^CNT_W-1.
  - cnt_clr clears both counters and wins over an increment.
  - Counters are not affected by flush.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for the default DATA_W (PC_W=32, IR_W=32).
  - the counter saturation value function.
  - the FSM state encoding: EMPTY=2'b00, HALF=2'b01, FULL=2'b11.
- One natural sub-module is sat_counter (CNT_W, inc, clr, q). It is instantiated twice.

Test Plan:
- Reset mid-stream: FULL with main=0x1, skid=0x2, then pulse rst low asynchronously -> out_valid=0, out_data=0, both counters 0 immediately, in_ready=1 on release.
- Streaming (SKID=1): in_valid=1 with data 0x10,0x11,0x12,… and out_ready=1 constantly -> out_data sequence identical, 1-cycle latency, in_ready never drops, stall_cnt=0.
- Backpressure: load 0xA, 0xB, then hold out_ready=0 for 5 cycles -> FULL, in_ready=0, out_data=0xA held, stall_cnt=5. Then raise out_ready -> out_data shows 0xA then 0xB, no loss or duplication.
- Flush collision: FULL with 0xA/0xB, and in the same cycle flush=1, in_valid=1, in_data=0xC, out_ready=0 -> next cycle out_valid=0, out_data=0, in_ready=1; 0xC never appears at the output.
- SKID=0 mode: out_ready=0 with the entry valid -> in_ready=0 in the same cycle. Raise out_ready and in_valid with 0x5 -> in_ready=1 combinationally, out_data=0x5 on the next edge.
- Counter saturation (CNT_W=4): out_valid=0 and out_ready=1 for 20 cycles -> bubble_cnt stops at 15. Then cnt_clr=1 while the increment condition is active -> bubble_cnt=0 on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register: default payload
// layout, occupancy encoding and the counter saturation helper.
package pipe_pkg;

  localparam int PC_W       = 32;
  localparam int IR_W       = 32;
  localparam int DATA_W_DEF = PC_W + IR_W;

  // Bit 0 is main_v and bit 1 is skid_v, so the encoding doubles as the valid flags.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

  function automatic logic [63:0] sat_max(input int unsigned width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating event counter with a synchronous clear that beats the increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != SAT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline stage with flush, optional two-entry skid
// buffer (registered in_ready) and saturating stall/bubble counters.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit SKID         = 1'b1,
  parameter int CNT_W        = 16,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_v & out_ready;

  generate
    if (SKID) begin : g_skid
      skid_state_e       state_q;
      skid_state_e       state_d;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] main_d;
      logic [DATA_W-1:0] skid_q;
      logic [DATA_W-1:0] skid_d;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            EMPTY: begin
              if (in_xfer) begin
                main_d  = in_data;
                state_d = HALF;
              end
            end
            HALF: begin
              if (in_xfer && out_xfer) begin
                main_d = in_data;
              end else if (out_xfer) begin
                state_d = EMPTY;
              end else if (in_xfer) begin
                skid_d  = in_data;
                state_d = FULL;
              end
            end
            FULL: begin
              // in_ready is low here, so only the drain of main can happen.
              if (out_xfer) begin
                main_d  = skid_q;
                state_d = HALF;
              end
            end
            default: begin
              state_d = EMPTY;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      assign in_ready  = ~state_q[1];
      assign main_v    = state_q[0];
      assign main_data = main_q;
    end else begin : g_single
      logic              valid_q;
      logic              valid_d;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] main_d;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
          main_d  = '0;
        end else if (in_xfer) begin
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (out_xfer) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign in_ready  = ~valid_q | out_ready;
      assign main_v    = valid_q;
      assign main_data = main_q;
    end
  endgenerate

  assign out_valid = main_v;
  assign out_data  = (ZERO_INVALID && !main_v) ? '0 : main_data;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_v & ~out_ready),
    .clr (cnt_clr),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~main_v & out_ready),
    .clr (cnt_clr),
    .q   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Two lanes (SKID=1 and SKID=0) checked against a queue-based occupancy model
// by per-lane monitors; directed scenarios followed by random traffic.
module tb_pipe_skid_reg;

  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int SATV = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  int rst_cnt = 0;

  logic          flush_s     [2];
  logic          in_valid_s  [2];
  logic          out_ready_s [2];
  logic          cnt_clr_s   [2];
  logic [DW-1:0] in_data_s   [2];
  logic          acc_last    [2];

  logic [1:0]         in_ready_w;
  logic [1:0]         out_valid_w;
  logic [1:0][DW-1:0] out_data_w;
  logic [1:0][CW-1:0] stall_w;
  logic [1:0][CW-1:0] bubble_w;

  task automatic chk(input string name, input int l, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", name, l, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam bit SK = (gi == 0);

    pipe_skid_reg #(
      .DATA_W       (DW),
      .SKID         (SK),
      .CNT_W        (CW),
      .ZERO_INVALID (1'b1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_n),
      .flush      (flush_s[gi]),
      .in_valid   (in_valid_s[gi]),
      .in_ready   (in_ready_w[gi]),
      .in_data    (in_data_s[gi]),
      .out_valid  (out_valid_w[gi]),
      .out_ready  (out_ready_s[gi]),
      .out_data   (out_data_w[gi]),
      .cnt_clr    (cnt_clr_s[gi]),
      .stall_cnt  (stall_w[gi]),
      .bubble_cnt (bubble_w[gi])
    );

    // Reference model: an ordered queue of accepted payloads plus two plain counters.
    logic [DW-1:0] sb[$];
    int            exp_stall  = 0;
    int            exp_bubble = 0;
    int            seen_rst   = 0;
    bit            pend_acc   = 1'b0;
    bit            pend_fl    = 1'b0;
    logic [DW-1:0] pend_d     = '0;

    always @(negedge clk) begin
      bit            exp_v;
      bit            exp_rdy;
      logic [DW-1:0] exp_d;
      if (!rst_n || (seen_rst != rst_cnt)) begin
        seen_rst   = rst_cnt;
        sb.delete();
        exp_stall  = 0;
        exp_bubble = 0;
        pend_acc   = 1'b0;
        pend_fl    = 1'b0;
      end else if (pend_fl) begin
        sb.delete();
      end else if (pend_acc) begin
        sb.push_back(pend_d);
      end

      if (rst_n) begin
        exp_v   = (sb.size() > 0);
        exp_d   = exp_v ? sb[0] : '0;
        exp_rdy = SK ? (sb.size() < 2) : (!exp_v || out_ready_s[gi]);
        chk("out_valid", gi, 64'(out_valid_w[gi]), 64'(exp_v));
        chk("out_data", gi, 64'(out_data_w[gi]), 64'(exp_d));
        chk("in_ready", gi, 64'(in_ready_w[gi]), 64'(exp_rdy));
        chk("stall_cnt", gi, 64'(stall_w[gi]), 64'(exp_stall));
        chk("bubble_cnt", gi, 64'(bubble_w[gi]), 64'(exp_bubble));

        if (exp_v && out_ready_s[gi]) begin
          $display("lane%0d out 0x%04h (expected 0x%04h) at %0t", gi, out_data_w[gi], exp_d, $time);
          void'(sb.pop_front());
        end

        if (cnt_clr_s[gi]) begin
          exp_stall  = 0;
          exp_bubble = 0;
        end else begin
          if (exp_v && !out_ready_s[gi] && exp_stall < SATV) exp_stall++;
          if (!exp_v && out_ready_s[gi] && exp_bubble < SATV) exp_bubble++;
        end

        pend_acc = in_valid_s[gi] && exp_rdy;
        pend_fl  = flush_s[gi];
        pend_d   = in_data_s[gi];
      end
    end
  end

  task automatic step();
    @(negedge clk);
    for (int l = 0; l < 2; l++) acc_last[l] = in_valid_s[l] & in_ready_w[l];
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int l, input bit v, input logic [DW-1:0] d, input bit ordy,
                        input bit fl = 1'b0, input bit clr = 1'b0);
    in_valid_s[l]  = v;
    in_data_s[l]   = d;
    out_ready_s[l] = ordy;
    flush_s[l]     = fl;
    cnt_clr_s[l]   = clr;
  endtask

  task automatic rand_run(input int l, input int cycles, input int tag0);
    int tag;
    int rdy_pct;
    tag = tag0;
    for (int i = 0; i < cycles; i++) begin
      if ((i % 50) == 0) rdy_pct = $urandom_range(10, 95);
      if (!(in_valid_s[l] && !acc_last[l])) begin
        in_valid_s[l] = ($urandom_range(0, 3) != 0);
        in_data_s[l]  = DW'(tag);
        tag++;
      end
      out_ready_s[l] = ($urandom_range(0, 99) < rdy_pct);
      flush_s[l]     = ($urandom_range(0, 39) == 0);
      cnt_clr_s[l]   = ($urandom_range(0, 79) == 0);
      step();
    end
    set_in(l, 1'b0, '0, 1'b1);
    repeat (4) step();
    set_in(l, 1'b0, '0, 1'b0);
    step();
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      set_in(l, 1'b0, '0, 1'b0);
      acc_last[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk("rst_out_valid", l, 64'(out_valid_w[l]), 64'd0);
      chk("rst_out_data", l, 64'(out_data_w[l]), 64'd0);
      chk("rst_stall", l, 64'(stall_w[l]), 64'd0);
      chk("rst_bubble", l, 64'(bubble_w[l]), 64'd0);
    end
    chk("rst_in_ready", 0, 64'(in_ready_w[0]), 64'd1);
    rst_n = 1'b1;
    step();

    // Streaming at full rate through the skid lane.
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1'b1, DW'(16'h10 + i), 1'b1);
      step();
    end
    set_in(0, 1'b0, '0, 1'b1);
    step();
    chk("stream_stall", 0, 64'(stall_w[0]), 64'd0);

    // Backpressure: two entries held for five stalled cycles, then drained in order.
    set_in(0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    set_in(0, 1'b1, 16'hA, 1'b0);
    step();
    set_in(0, 1'b1, 16'hB, 1'b0);
    step();
    set_in(0, 1'b0, '0, 1'b0);
    repeat (4) step();
    chk("bp_in_ready", 0, 64'(in_ready_w[0]), 64'd0);
    chk("bp_hold_data", 0, 64'(out_data_w[0]), 64'hA);
    chk("bp_stall5", 0, 64'(stall_w[0]), 64'd5);
    set_in(0, 1'b0, '0, 1'b1);
    step();
    chk("bp_second", 0, 64'(out_data_w[0]), 64'hB);
    repeat (2) step();
    chk("bp_drained", 0, 64'(out_valid_w[0]), 64'd0);

    // Flush collides with a full stage and a new input.
    set_in(0, 1'b1, 16'hA, 1'b0);
    step();
    set_in(0, 1'b1, 16'hB, 1'b0);
    step();
    chk("fl_full_ready", 0, 64'(in_ready_w[0]), 64'd0);
    set_in(0, 1'b1, 16'hC, 1'b0, 1'b1);
    step();
    set_in(0, 1'b0, '0, 1'b0);
    chk("fl_out_valid", 0, 64'(out_valid_w[0]), 64'd0);
    chk("fl_out_data", 0, 64'(out_data_w[0]), 64'd0);
    chk("fl_in_ready", 0, 64'(in_ready_w[0]), 64'd1);
    set_in(0, 1'b0, '0, 1'b1);
    repeat (3) step();

    // Asynchronous reset in the middle of a cycle while FULL.
    set_in(0, 1'b1, 16'h1, 1'b0);
    step();
    set_in(0, 1'b1, 16'h2, 1'b0);
    step();
    set_in(0, 1'b0, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 0, 64'(out_valid_w[0]), 64'd0);
    chk("arst_out_data", 0, 64'(out_data_w[0]), 64'd0);
    chk("arst_stall", 0, 64'(stall_w[0]), 64'd0);
    chk("arst_bubble", 0, 64'(bubble_w[0]), 64'd0);
    rst_cnt++;
    #1;
    rst_n = 1'b1;
    step();
    chk("arst_in_ready", 0, 64'(in_ready_w[0]), 64'd1);

    // Bubble counter saturation then clear against an active increment.
    set_in(0, 1'b0, '0, 1'b1);
    repeat (20) step();
    chk("sat_bubble", 0, 64'(bubble_w[0]), 64'(SATV));
    set_in(0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step();
    chk("clr_bubble", 0, 64'(bubble_w[0]), 64'd0);
    set_in(0, 1'b0, '0, 1'b0);
    step();

    rand_run(0, 400, 16'h100);

    // Single-entry lane: combinational in_ready.
    set_in(1, 1'b1, 16'h4, 1'b0);
    step();
    set_in(1, 1'b0, '0, 1'b0);
    #1;
    chk("s0_ready_low", 1, 64'(in_ready_w[1]), 64'd0);
    set_in(1, 1'b1, 16'h5, 1'b1);
    #1;
    chk("s0_ready_comb", 1, 64'(in_ready_w[1]), 64'd1);
    step();
    chk("s0_out_valid", 1, 64'(out_valid_w[1]), 64'd1);
    chk("s0_out_data", 1, 64'(out_data_w[1]), 64'h5);
    set_in(1, 1'b0, '0, 1'b1);
    repeat (2) step();

    rand_run(1, 400, 16'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
